// File: rtl/bsg_fifo_rolly_replay_ctrl_pkg.sv
// Shared types and helpers for the rollback-FIFO replay sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bsg_fifo_rolly_replay_pkg;

    typedef enum logic [1:0] {
        SEND   = 2'd0,
        WAIT   = 2'd1,
        REWIND = 2'd2,
        COMMIT = 2'd3
    } state_e;

    // The packet "last" flag rides in the top bit of each FIFO word.
    function automatic int last_bit_idx(input int width);
        return width - 1;
    endfunction

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bsg_fifo_rolly_replay_ctrl_if.sv
// Consumer-side link of the replay sequencer: beat stream out, ready and ack/nack back.
// Latency: n/a (wires only).
// Backpressure: valid-then-ready on the beat stream; ack/nack are single-cycle pulses.
interface bsg_fifo_rolly_replay_ctrl_if #(
    parameter int width_p = 8
);
    logic [width_p-1:0] data_o;
    logic               v_o;
    logic               ready_i;
    logic               ack_v_i;
    logic               nack_v_i;

    modport master (
        output data_o,
        output v_o,
        input  ready_i,
        input  ack_v_i,
        input  nack_v_i
    );

    modport slave (
        input  data_o,
        input  v_o,
        output ready_i,
        output ack_v_i,
        output nack_v_i
    );
endinterface

// File: rtl/bsg_fifo_rolly_replay_ctrl_timer.sv
// Response timer: saturating up-counter with synchronous clear, flags expiry at timeout_p-1.
// Latency: expired_o is combinational from the count register.
// Backpressure: none; counts whenever enabled.
module bsg_fifo_rolly_replay_timer #(
    parameter int timeout_p = 255
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int cnt_w_lp = $clog2(timeout_p + 1);

    logic [cnt_w_lp-1:0] cnt_q;

    // Count up while enabled, hold at all-ones, clear takes priority.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {cnt_w_lp{1'b1}})) begin
            cnt_q <= cnt_q + cnt_w_lp'(1);
        end
    end

    assign expired_o = (cnt_q == cnt_w_lp'(timeout_p - 1));

endmodule

// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// Read-side replay sequencer: streams one packet, awaits ack/nack, commits or rewinds the FIFO.
// Latency: data_o is a pass-through; response to next beat is 2 cycles.
// Backpressure: beats held while ready_i low; optional counters under BSG_FIFO_ROLLY_REPLAY_STATS_EN.
module bsg_fifo_rolly_replay_ctrl
    import bsg_fifo_rolly_replay_pkg::*;
#(
    parameter int width_p       = 8,
    parameter int timeout_p     = 255,
    parameter int max_retries_p = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [width_p-1:0]   fifo_data_i,
    input  logic                 fifo_v_i,
    output logic                 fifo_yumi_o,
    output logic                 fifo_r_incr_o,
    output logic                 fifo_r_rewind_o,
    output logic                 fifo_r_forward_o,
    bsg_fifo_rolly_replay_ctrl_if.master link,
    output logic                 drop_o,
    output logic                 spurious_o
`ifdef BSG_FIFO_ROLLY_REPLAY_STATS_EN
    ,
    output logic [31:0]          pkt_cnt_o,
    output logic [31:0]          replay_cnt_o,
    output logic [15:0]          drop_cnt_o
`endif
);
    localparam int last_lp    = last_bit_idx(width_p);
    localparam int retry_w_lp = cnt_width(max_retries_p);
    localparam logic [retry_w_lp-1:0] retry_max_lp = retry_w_lp'(max_retries_p);

    localparam logic [1:0] ST_SEND   = SEND;
    localparam logic [1:0] ST_WAIT   = WAIT;
    localparam logic [1:0] ST_REWIND = REWIND;
    localparam logic [1:0] ST_COMMIT = COMMIT;

    logic [1:0]            state_q, state_n;
    logic [retry_w_lp-1:0] retry_q, retry_n;
    logic                  drop_q, drop_n;
    logic                  spurious_q;
    logic                  expired;
    logic                  in_wait;
    logic                  fail;
    logic                  beat_v;
    logic                  beat_yumi;

    assign in_wait = (state_q == ST_WAIT);

    bsg_fifo_rolly_replay_timer #(
        .timeout_p(timeout_p)
    ) timer (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (!in_wait),
        .en_i     (in_wait),
        .expired_o(expired)
    );

    // fifo_v_i is raw from the FIFO, so gate it with reset to keep v_o low while reset is held.
    assign beat_v    = (state_q == ST_SEND) && fifo_v_i && reset_n_i;
    assign beat_yumi = beat_v && link.ready_i;

    // A nack wins over a simultaneous ack; the timeout only counts when nothing answered.
    assign fail = link.nack_v_i || (expired && !link.ack_v_i);

    // Next-state, retry accounting and the "this commit is a drop" flag.
    always_comb begin
        state_n = state_q;
        retry_n = retry_q;
        drop_n  = drop_q;
        case (state_q)
            ST_SEND: begin
                if (beat_yumi && fifo_data_i[last_lp]) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fail) begin
                    if (retry_q == retry_max_lp) begin
                        state_n = ST_COMMIT;
                        drop_n  = 1'b1;
                    end else begin
                        state_n = ST_REWIND;
                        retry_n = retry_q + retry_w_lp'(1);
                    end
                end else if (link.ack_v_i) begin
                    state_n = ST_COMMIT;
                    drop_n  = 1'b0;
                end
            end
            ST_REWIND: begin
                state_n = ST_SEND;
            end
            ST_COMMIT: begin
                state_n = ST_SEND;
                retry_n = '0;
                drop_n  = 1'b0;
            end
            default: begin
                state_n = ST_SEND;
                retry_n = '0;
                drop_n  = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_SEND;
            retry_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            retry_q <= retry_n;
            drop_q  <= drop_n;
        end
    end

    // Sticky flag for responses arriving when no packet is awaiting one.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            spurious_q <= 1'b0;
        end else if ((link.ack_v_i || link.nack_v_i) && !in_wait) begin
            spurious_q <= 1'b1;
        end
    end

    assign link.data_o      = fifo_data_i;
    assign link.v_o         = beat_v;
    assign fifo_yumi_o      = beat_yumi;
    assign fifo_r_incr_o    = 1'b0;
    assign fifo_r_rewind_o  = (state_q == ST_REWIND);
    assign fifo_r_forward_o = (state_q == ST_COMMIT);
    assign drop_o           = (state_q == ST_COMMIT) && drop_q;
    assign spurious_o       = spurious_q;

`ifdef BSG_FIFO_ROLLY_REPLAY_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] replay_cnt_q;
    logic [15:0] drop_cnt_q;

    // Wrapping event counters: delivered packets, replays, drops.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pkt_cnt_q    <= '0;
            replay_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (fifo_r_forward_o && !drop_q) pkt_cnt_q    <= pkt_cnt_q + 32'd1;
            if (fifo_r_rewind_o)             replay_cnt_q <= replay_cnt_q + 32'd1;
            if (drop_o)                      drop_cnt_q   <= drop_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt_o    = pkt_cnt_q;
    assign replay_cnt_o = replay_cnt_q;
    assign drop_cnt_o   = drop_cnt_q;
`endif

endmodule
